// File: rtl/scene_recovery_if.sv
// Pixel/transmission stream into scene recovery and recovered-pixel stream out,
// plus the atmospheric-light load strobe.
interface scene_recovery_if;
  logic [23:0] atm_light;
  logic        atm_load;
  logic [23:0] input_pixel;
  logic [7:0]  transmission;
  logic        input_is_valid;
  logic [23:0] output_pixel;
  logic        output_valid;
  logic        frame_done;
  logic        a_loaded;

  modport master (
    output atm_light, atm_load, input_pixel, transmission, input_is_valid,
    input  output_pixel, output_valid, frame_done, a_loaded
  );

  modport slave (
    input  atm_light, atm_load, input_pixel, transmission, input_is_valid,
    output output_pixel, output_valid, frame_done, a_loaded
  );
endinterface

// File: rtl/scene_recovery.sv
// Haze-free recovery J = A + (I - A) * 255 / max(t, T0) per channel, with a
// reciprocal ROM, output saturation and a frame beat counter.
module scene_recovery #(
  parameter int unsigned WIDTH  = 512,
  parameter int unsigned HEIGHT = 512,
  parameter int unsigned T0     = 26
) (
  input  logic             clk,
  input  logic             rst,
  scene_recovery_if.slave  bus
);

  localparam int unsigned PIXELS  = WIDTH * HEIGHT;
  localparam int unsigned CW      = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam logic [CW-1:0] LAST  = CW'(PIXELS - 1);
  localparam logic [7:0] T_FLOOR  = 8'(T0);
  localparam int unsigned RECIP_NUM = 1044480;  // 255 * 2^12

  // Reciprocal table; entries below 16 are never addressed since tm >= T0 >= 16
  logic [15:0] recip_rom [256];
  for (genvar i = 0; i < 256; i++) begin : g_rom
    localparam int unsigned DEN = (i < 16) ? 16 : i;
    assign recip_rom[i] = (i < 16) ? '0 : 16'(RECIP_NUM / DEN);
  end

  logic [23:0] a_reg;
  logic        a_loaded_q;

  // Capture register: the accept edge registers I, t and the A in force, so the
  // four arithmetic stages below put output_valid exactly four edges later.
  logic        in_valid;
  logic [23:0] in_pix;
  logic [7:0]  in_t;
  logic [23:0] in_a;

  logic              s1_valid;
  logic [7:0]        s1_tm;
  logic signed [8:0] s1_diff [3];
  logic [7:0]        s1_a    [3];

  logic              s2_valid;
  logic [15:0]       s2_recip;
  logic signed [8:0] s2_diff [3];
  logic [7:0]        s2_a    [3];

  logic               s3_valid;
  logic signed [24:0] s3_prod [3];
  logic [7:0]         s3_a    [3];

  logic [23:0]   out_pix;
  logic          out_valid;
  logic          out_done;
  logic [CW-1:0] beat_cnt;

  logic signed [13:0] sum [3];
  logic [7:0]         sat [3];

  // Floor via arithmetic shift, add A back, clamp to 0..255
  always_comb begin
    for (int unsigned c = 0; c < 3; c++) begin
      sum[c] = 14'(s3_prod[c] >>> 12) + $signed({6'b0, s3_a[c]});
      sat[c] = '0;
      if (sum[c][13])
        sat[c] = '0;
      else if (sum[c][12:8] != '0)
        sat[c] = '1;
      else
        sat[c] = sum[c][7:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_reg      <= '0;
      a_loaded_q <= 1'b0;
      in_valid   <= 1'b0;
      in_pix     <= '0;
      in_t       <= '0;
      in_a       <= '0;
      s1_valid   <= 1'b0;
      s1_tm      <= '0;
      s2_valid   <= 1'b0;
      s2_recip   <= '0;
      s3_valid   <= 1'b0;
      out_pix    <= '0;
      out_valid  <= 1'b0;
      out_done   <= 1'b0;
      beat_cnt   <= '0;
      for (int unsigned c = 0; c < 3; c++) begin
        s1_diff[c] <= '0;
        s1_a[c]    <= '0;
        s2_diff[c] <= '0;
        s2_a[c]    <= '0;
        s3_prod[c] <= '0;
        s3_a[c]    <= '0;
      end
    end else begin
      if (bus.atm_load) begin
        a_reg      <= bus.atm_light;
        a_loaded_q <= 1'b1;
      end

      // Pixels arriving before any A has been latched are dropped here
      in_valid <= bus.input_is_valid & a_loaded_q;
      in_pix   <= bus.input_pixel;
      in_t     <= bus.transmission;
      in_a     <= a_reg;

      s1_valid <= in_valid;
      s1_tm    <= (in_t < T_FLOOR) ? T_FLOOR : in_t;
      for (int unsigned c = 0; c < 3; c++) begin
        s1_diff[c] <= $signed({1'b0, in_pix[8*c +: 8]}) - $signed({1'b0, in_a[8*c +: 8]});
        s1_a[c]    <= in_a[8*c +: 8];
      end

      s2_valid <= s1_valid;
      s2_recip <= recip_rom[s1_tm];
      for (int unsigned c = 0; c < 3; c++) begin
        s2_diff[c] <= s1_diff[c];
        s2_a[c]    <= s1_a[c];
      end

      s3_valid <= s2_valid;
      for (int unsigned c = 0; c < 3; c++) begin
        s3_prod[c] <= 25'($signed({{17{s2_diff[c][8]}}, s2_diff[c]}) *
                          $signed({10'b0, s2_recip}));
        s3_a[c]    <= s2_a[c];
      end

      out_valid <= s3_valid;
      out_done  <= 1'b0;
      if (s3_valid) begin
        for (int unsigned c = 0; c < 3; c++)
          out_pix[8*c +: 8] <= sat[c];
        if (beat_cnt == LAST) begin
          out_done <= 1'b1;
          beat_cnt <= '0;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.output_pixel = out_pix;
  assign bus.output_valid = out_valid;
  assign bus.frame_done   = out_done;
  assign bus.a_loaded     = a_loaded_q;

endmodule

// File: tb/tb_scene_recovery.sv
// Scoreboard bench for scene_recovery: expected pixels and arrival cycles are
// queued at drive time and popped as output beats appear.
module tb_scene_recovery;
  localparam int unsigned W    = 8;
  localparam int unsigned H    = 4;
  localparam int unsigned NPIX = W * H;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  scene_recovery_if bus();

  scene_recovery #(.WIDTH(W), .HEIGHT(H), .T0(26)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [23:0] pix;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        e_mon;
  int unsigned cyc      = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned beat     = 0;
  int unsigned fd_count = 0;
  int unsigned n_out    = 0;
  logic [23:0] m_a      = '0;
  logic        m_loaded = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: floor division done explicitly, clamp to 0..255
  function automatic logic [23:0] model(input logic [23:0] i, input logic [23:0] a,
                                        input logic [7:0] t);
    int tm, r, d, p, q, s;
    logic [23:0] j;
    j  = '0;
    tm = (int'(t) < 26) ? 26 : int'(t);
    r  = 1044480 / tm;
    for (int c = 0; c < 3; c++) begin
      d = int'(i[8*c +: 8]) - int'(a[8*c +: 8]);
      p = d * r;
      q = (p >= 0) ? p / 4096 : -((-p + 4095) / 4096);
      s = q + int'(a[8*c +: 8]);
      if (s < 0) s = 0;
      if (s > 255) s = 255;
      j[8*c +: 8] = 8'(s);
    end
    return j;
  endfunction

  // Called at posedge+1; inputs are captured on the next edge
  task automatic drive(input logic v, input logic [23:0] pix, input logic [7:0] t,
                       input logic ld, input logic [23:0] a, input int forced = -1);
    bus.input_is_valid = v;
    bus.input_pixel    = pix;
    bus.transmission   = t;
    bus.atm_load       = ld;
    bus.atm_light      = a;
    if (v && m_loaded)
      sb.push_back('{pix: (forced >= 0) ? 24'(forced) : model(pix, m_a, t), cyc: cyc + 5});
    @(posedge clk); #1;
    if (ld) begin
      m_a      = a;
      m_loaded = 1'b1;
    end
    bus.input_is_valid = 1'b0;
    bus.atm_load       = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && sb.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    check("drain", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (bus.output_valid) begin
        n_out++;
        if (sb.size() == 0) begin
          check("unexpected_valid", bus.output_valid, 0);
        end else begin
          e_mon = sb.pop_front();
          check("pixel", bus.output_pixel, e_mon.pix);
          check("latency", cyc, e_mon.cyc);
          check("frame_done", bus.frame_done, (beat == NPIX - 1) ? 1 : 0);
          beat = (beat == NPIX - 1) ? 0 : beat + 1;
        end
      end else begin
        check("frame_done_idle", bus.frame_done, 0);
      end
      if (bus.frame_done) fd_count++;
    end
  end

  initial begin
    logic v;
    int unsigned sent;
    bus.input_is_valid = 1'b0;
    bus.input_pixel    = '0;
    bus.transmission   = '0;
    bus.atm_load       = 1'b0;
    bus.atm_light      = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_pixel", bus.output_pixel, 0);
    check("rst_valid", bus.output_valid, 0);
    check("rst_done", bus.frame_done, 0);
    check("rst_a_loaded", bus.a_loaded, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // No A yet: all dropped, including the pixel sharing the first load cycle
    for (int k = 0; k < 3; k++) drive(1'b1, 24'h123456, 8'd255, 1'b0, '0);
    drive(1'b1, 24'h123456, 8'd255, 1'b1, 24'h646464);
    check("a_loaded_set", bus.a_loaded, 1);
    idle(6);

    drive(1'b1, 24'h123456, 8'd255, 1'b0, '0, 32'h123456);   // identity
    drive(1'b1, 24'h969696, 8'd128, 1'b0, '0, 32'hC7C7C7);   // R = 8160
    drive(1'b1, 24'hFFFFFF, 8'd0,   1'b0, '0, 32'hFFFFFF);   // floor to T0, saturate high
    // New A in the same cycle as a pixel: that pixel still uses A = 100
    drive(1'b1, 24'hFFFFFF, 8'd0,   1'b1, 24'hC8C8C8, 32'hFFFFFF);
    drive(1'b1, 24'h000000, 8'd26,  1'b0, '0, 32'h000000);
    drive(1'b1, 24'h646464, 8'd128, 1'b0, '0, 32'h000000);
    idle(2);
    for (int k = 0; k < 6; k++) drive(1'b1, 24'($urandom), 8'($urandom), 1'b0, '0);
    drive(1'b1, 24'h10F080, 8'd40, 1'b1, 24'h208040);
    for (int k = 0; k < 6; k++) drive(1'b1, 24'($urandom), 8'($urandom), 1'b0, '0);
    drain();

    // Reset with three pixels in flight
    for (int k = 0; k < 3; k++) drive(1'b1, 24'($urandom), 8'd200, 1'b0, '0);
    rst = 1'b0;
    #1;
    check("midrst_valid", bus.output_valid, 0);
    check("midrst_pixel", bus.output_pixel, 0);
    check("midrst_done", bus.frame_done, 0);
    check("midrst_a_loaded", bus.a_loaded, 0);
    sb.delete();
    beat = 0; fd_count = 0; m_a = '0; m_loaded = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    idle(8);
    for (int k = 0; k < 3; k++) drive(1'b1, 24'($urandom), 8'd255, 1'b0, '0);
    check("post_rst_a_loaded", bus.a_loaded, 0);
    idle(6);

    // Two frames with random bubbles
    drive(1'b0, '0, '0, 1'b1, 24'($urandom));
    n_out = 0;
    sent  = 0;
    while (sent < 2 * NPIX) begin
      v = ($urandom_range(0, 3) != 0);
      drive(v, 24'($urandom), 8'($urandom), 1'b0, '0);
      if (v) sent++;
    end
    drain();
    check("frame_out_count", n_out, 2 * NPIX);
    check("frame_done_count", fd_count, 2);
    check("beat_wrapped", beat, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
